// File: rtl/sort_fetch.sv
// AXI4 read master: fetches up to FETCH_WIDTH/DATA_WIDTH single-beat reads and
// shifts them into one wide register, first beat ending up most significant.
module sort_fetch #(
    parameter int ID_WIDTH        = 1,
    parameter int ARUSER_WIDTH    = 9,
    parameter int PASID_WIDTH     = 9,
    parameter int FETCH_WIDTH     = 32768,
    parameter int DATA_WIDTH      = 1024,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_start,
    output logic                    fetch_done,
    output logic                    fetch_error,
    input  logic [PASID_WIDTH-1:0]  fetch_pasid,
    input  logic [ADDR_WIDTH-1:0]   fetch_start_addr,
    input  logic [5:0]              fetch_beat_num,
    output logic [FETCH_WIDTH-1:0]  fetch_data,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [3:0]              m_axi_arcache,
    output logic                    m_axi_arlock,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int         BEATS     = FETCH_WIDTH / DATA_WIDTH;
    localparam logic [5:0] BEATS_MAX = 6'(BEATS);
    localparam logic [5:0] OUT_MAX   = 6'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

    state_t     state;
    logic [5:0] beat_tgt;
    logic [5:0] ar_cnt;
    logic [5:0] r_cnt;
    logic [5:0] outstanding;
    logic       ar_fire;
    logic [5:0] ar_cnt_nxt;
    logic [5:0] out_nxt;
    logic       unused;

    assign m_axi_arid    = '0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'd7;
    assign m_axi_arburst = 2'd1;
    assign m_axi_arcache = 4'd3;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_rready  = 1'b1;
    assign unused        = &{1'b0, m_axi_rid, m_axi_rlast};

    assign ar_fire    = m_axi_arvalid & m_axi_arready;
    assign ar_cnt_nxt = ar_cnt + {5'd0, ar_fire};
    assign out_nxt    = outstanding + {5'd0, ar_fire} - {5'd0, m_axi_rvalid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat_tgt      <= '0;
            ar_cnt        <= '0;
            r_cnt         <= '0;
            outstanding   <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_aruser  <= '0;
            fetch_done    <= 1'b0;
            fetch_error   <= 1'b0;
            fetch_data    <= '0;
        end else begin
            // R beats are always accepted; the start branch below overrides on the same edge
            if (m_axi_rvalid) begin
                fetch_data <= {fetch_data[FETCH_WIDTH-DATA_WIDTH-1:0], m_axi_rdata};
                r_cnt      <= r_cnt + 6'd1;
                if (m_axi_rresp != 2'b00) begin
                    fetch_error <= 1'b1;
                end
            end
            outstanding <= out_nxt;

            case (state)
                IDLE, DONE: begin
                    if (fetch_start) begin
                        beat_tgt      <= (fetch_beat_num > BEATS_MAX) ? BEATS_MAX : fetch_beat_num;
                        m_axi_araddr  <= fetch_start_addr;
                        m_axi_aruser  <= ARUSER_WIDTH'(fetch_pasid);
                        m_axi_arvalid <= 1'b0;
                        ar_cnt        <= '0;
                        r_cnt         <= '0;
                        outstanding   <= '0;
                        fetch_data    <= '0;
                        fetch_done    <= 1'b0;
                        fetch_error   <= 1'b0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (beat_tgt == 6'd0) begin
                        fetch_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (ar_fire) begin
                            ar_cnt       <= ar_cnt_nxt;
                            m_axi_araddr <= m_axi_araddr + ADDR_WIDTH'(128);
                        end
                        if (ar_cnt_nxt == beat_tgt) begin
                            m_axi_arvalid <= 1'b0;
                            state         <= DRAIN;
                        end else if (m_axi_arvalid && !m_axi_arready) begin
                            m_axi_arvalid <= 1'b1;
                        end else begin
                            m_axi_arvalid <= (out_nxt < OUT_MAX);
                        end
                    end
                end
                DRAIN: begin
                    m_axi_arvalid <= 1'b0;
                    if (r_cnt == beat_tgt) begin
                        fetch_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_fetch.sv
// Directed bench for sort_fetch with a small AXI read responder returning
// address-derived data two cycles after each accepted AR.
module tb_sort_fetch;

    localparam int FW = 32768;
    localparam int DW = 1024;
    localparam int AW = 64;

    logic          clk;
    logic          rst_n;
    logic          fetch_start;
    logic          fetch_done;
    logic          fetch_error;
    logic [8:0]    fetch_pasid;
    logic [AW-1:0] fetch_start_addr;
    logic [5:0]    fetch_beat_num;
    logic [FW-1:0] fetch_data;
    logic [0:0]    arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arcache;
    logic          arlock;
    logic [2:0]    arprot;
    logic [3:0]    arqos;
    logic [8:0]    aruser;
    logic          arvalid;
    logic          arready;
    logic [0:0]    rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    sort_fetch dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .fetch_done(fetch_done),
        .fetch_error(fetch_error), .fetch_pasid(fetch_pasid), .fetch_start_addr(fetch_start_addr),
        .fetch_beat_num(fetch_beat_num), .fetch_data(fetch_data),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arcache(arcache), .m_axi_arlock(arlock),
        .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_aruser(aruser),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata),
        .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ar_count = 0;
    int r_beats = 0;
    int ar_seen = 0;
    int max_ob = 0;
    int err_idx = -1;
    bit r_en = 1'b1;
    time last_r_time = 0;
    time done_time = 0;
    logic [63:0] ar_log [64];
    logic [63:0] q_addr [$];
    int          q_due [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] pat(input logic [63:0] a);
        return {16{a ^ 64'hDEAD_BEEF_0000_0000}};
    endfunction

    function automatic logic [FW-1:0] model(input logic [63:0] a0, input int n);
        logic [FW-1:0] e;
        e = '0;
        for (int k = 0; k < n; k++) begin
            e = {e[FW-DW-1:0], pat(a0 + 64'(128 * k))};
        end
        return e;
    endfunction

    // Responder: decisions made on the falling edge so inputs are stable at the rising edge
    initial begin
        logic [63:0] a;
        int ob;
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                q_addr.delete();
                q_due.delete();
                rvalid = 1'b0;
                continue;
            end
            if (r_en && q_due.size() > 0 && q_due[0] <= cyc) begin
                a = q_addr.pop_front();
                void'(q_due.pop_front());
                rvalid = 1'b1;
                rdata  = pat(a);
                rresp  = (r_beats == err_idx) ? 2'b10 : 2'b00;
                r_beats++;
                last_r_time = $time;
            end else begin
                rvalid = 1'b0;
                rresp  = 2'b00;
            end
            if (arvalid) ar_seen++;
            if (arvalid && arready) begin
                q_addr.push_back(araddr);
                q_due.push_back(cyc + 2);
                if (ar_count < 64) ar_log[ar_count] = araddr;
                ar_count++;
            end
            ob = ar_count - r_beats;
            if (ob > max_ob) max_ob = ob;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [FW-1:0] exp);
        checks++;
        assert (fetch_data === exp) else begin
            failures++;
            $error("FAIL %s observed_low=%0h expected_low=%0h observed_top=%0h expected_top=%0h",
                   tag, fetch_data[63:0], exp[63:0], fetch_data[FW-1:FW-64], exp[FW-1:FW-64]);
        end
    endtask

    task automatic do_start(input logic [5:0] num, input logic [63:0] addr, input logic [8:0] pasid);
        tick(1);
        fetch_beat_num   = num;
        fetch_start_addr = addr;
        fetch_pasid      = pasid;
        fetch_start      = 1'b1;
        ar_count = 0;
        r_beats  = 0;
        ar_seen  = 0;
        max_ob   = 0;
        tick(1);
        fetch_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!fetch_done && n < budget) begin
            tick(1);
            n++;
        end
        done_time = $time;
        check("done_within_budget", 64'(fetch_done), 64'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        fetch_start = 1'b0;
        fetch_pasid = '0;
        fetch_start_addr = '0;
        fetch_beat_num = '0;
        arready = 1'b1;
        rid = '0;
        rlast = 1'b1;
        tick(3);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_done", 64'(fetch_done), 64'd0);
        check("rst_error", 64'(fetch_error), 64'd0);
        check("rst_araddr", araddr, 64'd0);
        check("rst_aruser", 64'(aruser), 64'd0);
        check_data("rst_data", '0);
        rst_n = 1'b1;
        tick(2);

        // 1: four beats at 0x1000
        do_start(6'd4, 64'h1000, 9'h155);
        wait_done(100);
        check("t1_ar_count", 64'(ar_count), 64'd4);
        check("t1_addr0", ar_log[0], 64'h1000);
        check("t1_addr1", ar_log[1], 64'h1080);
        check("t1_addr2", ar_log[2], 64'h1100);
        check("t1_addr3", ar_log[3], 64'h1180);
        check("t1_aruser", 64'(aruser), 64'h155);
        check("t1_done_latency", 64'(done_time - last_r_time), 64'd21);
        check("t1_const_ar", {arid, arlen, arsize, arburst, arcache, arlock, arprot, arqos, rready},
              {1'b0, 8'd0, 3'd7, 2'd1, 4'd3, 1'b0, 3'd0, 4'd0, 1'b1});
        check_data("t1_data", model(64'h1000, 4));

        // 2: 32 beats with R withheld, outstanding must cap at 8
        r_en = 1'b0;
        do_start(6'd32, 64'h20000, 9'h0A3);
        tick(50);
        check("t2_ar_capped", 64'(ar_count), 64'd8);
        check("t2_arvalid_low", 64'(arvalid), 64'd0);
        r_en = 1'b1;
        wait_done(500);
        check("t2_ar_total", 64'(ar_count), 64'd32);
        check("t2_r_total", 64'(r_beats), 64'd32);
        check("t2_max_outstanding", 64'(max_ob), 64'd8);
        check("t2_top_beat", fetch_data[FW-1:FW-64], pat(64'h20000) >> (DW - 64));
        check_data("t2_data", model(64'h20000, 32));

        // 3: 40 requested, clamped to 32
        do_start(6'd40, 64'h40000, 9'h001);
        wait_done(500);
        check("t3_ar_total", 64'(ar_count), 64'd32);
        check("t3_r_total", 64'(r_beats), 64'd32);
        check("t3_done_latency", 64'(done_time - last_r_time), 64'd21);
        check_data("t3_data", model(64'h40000, 32));

        // 4: zero beats
        do_start(6'd0, 64'h5000, 9'h002);
        check("t4_done_early", 64'(fetch_done), 64'd0);
        tick(1);
        check("t4_done_two_cycles", 64'(fetch_done), 64'd1);
        check("t4_no_arvalid", 64'(ar_seen), 64'd0);
        check_data("t4_data_zero", '0);

        // 5: error response on the second beat
        err_idx = 1;
        do_start(6'd3, 64'h6000, 9'h003);
        wait_done(100);
        check("t5_error", 64'(fetch_error), 64'd1);
        check("t5_r_total", 64'(r_beats), 64'd3);
        check_data("t5_data", model(64'h6000, 3));
        err_idx = -1;
        do_start(6'd1, 64'h7000, 9'h004);
        check("t5_error_cleared", 64'(fetch_error), 64'd0);
        wait_done(100);
        check("t5_error_stays_clear", 64'(fetch_error), 64'd0);

        // 6a: start pulsed during DRAIN is ignored
        r_en = 1'b0;
        do_start(6'd4, 64'h8000, 9'h005);
        n = 0;
        while (ar_count < 4 && n < 100) begin
            tick(1);
            n++;
        end
        tick(2);
        fetch_beat_num   = 6'd10;
        fetch_start_addr = 64'h9000;
        fetch_start      = 1'b1;
        tick(1);
        fetch_start = 1'b0;
        tick(3);
        check("t6_no_new_ar", 64'(ar_count), 64'd4);
        check("t6_arvalid_low", 64'(arvalid), 64'd0);
        check("t6_not_done", 64'(fetch_done), 64'd0);
        r_en = 1'b1;
        wait_done(100);
        check("t6_ar_total", 64'(ar_count), 64'd4);
        check_data("t6_data", model(64'h8000, 4));

        // 6b: asynchronous reset in the middle of REQ
        do_start(6'd32, 64'hA000, 9'h006);
        tick(10);
        check("t6_arvalid_in_req", 64'(arvalid), 64'd1);
        check("t6_data_nonzero", 64'(fetch_data != '0), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_arvalid", 64'(arvalid), 64'd0);
        check("t6_rst_done", 64'(fetch_done), 64'd0);
        check_data("t6_rst_data", '0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("t6_idle_after_rst", 64'(arvalid), 64'd0);
        check("t6_idle_done", 64'(fetch_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort_fetch.md
Name: sort_fetch

Overview:
- AXI4 read master that loads one block of unsorted keys from host memory into a wide flat register for the sort engine.
- Issues single-beat 1024-bit reads and shifts each returned beat into a FETCH_WIDTH-bit vector.
- Raises fetch_done once every requested beat has returned.
- Sits directly upstream of the sort core. Mirror of sort_return on the AXI read channels.

Parameters:
- ID_WIDTH, 1, AXI ID width; arid is tied to 0.
- ARUSER_WIDTH, 9, aruser width; carries the PASID.
- PASID_WIDTH, 9, width of fetch_pasid.
- FETCH_WIDTH, 32768, width of fetch_data (32 beats).
- DATA_WIDTH, 1024, AXI data width.
- ADDR_WIDTH, 64, AXI address width.
- MAX_OUTSTANDING, 8, maximum number of accepted AR requests still awaiting R data (1..31).

Ports:
- clk input 1 system clock
- rst_n input 1 asynchronous active-low reset
- fetch_start input 1 single-cycle request pulse
- fetch_done output 1 block fully received
- fetch_error output 1 sticky: some rresp was nonzero during this fetch
- fetch_pasid input PASID_WIDTH driven onto aruser
- fetch_start_addr input ADDR_WIDTH byte address of first beat; 128-byte aligned
- fetch_beat_num input 6 number of beats to read
- fetch_data output FETCH_WIDTH assembled block
- m_axi_arid output ID_WIDTH constant 0
- m_axi_araddr output ADDR_WIDTH read address
- m_axi_arlen output 8 constant 0
- m_axi_arsize output 3 constant 7
- m_axi_arburst output 2 constant 1 (INCR)
- m_axi_arcache output 4 constant 3
- m_axi_arlock output 1 constant 0
- m_axi_arprot output 3 constant 0
- m_axi_arqos output 4 constant 0
- m_axi_aruser output ARUSER_WIDTH latched fetch_pasid
- m_axi_arvalid output 1 address valid
- m_axi_arready input 1 address ready
- m_axi_rid input ID_WIDTH ignored
- m_axi_rdata input DATA_WIDTH read data
- m_axi_rresp input 2 read response
- m_axi_rlast input 1 ignored (all bursts are length 1)
- m_axi_rvalid input 1 data valid
- m_axi_rready output 1 constant 1

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, arvalid 0, araddr 0, aruser 0, fetch_done 0, fetch_error 0, fetch_data 0, all counters 0.
- Start latching: on fetch_start in IDLE or DONE, the following are latched on the next edge:
  - beat_tgt = min(fetch_beat_num, FETCH_WIDTH/DATA_WIDTH)
  - araddr = fetch_start_addr
  - aruser = fetch_pasid
  - ar_cnt, r_cnt and outstanding are cleared; fetch_data, fetch_done and fetch_error are cleared.
- fetch_start while in REQ or DRAIN is ignored. No AXI transaction is ever abandoned.
- State IDLE: go to REQ on fetch_start.
- State REQ:
  - arvalid = (ar_cnt < beat_tgt) && (outstanding < MAX_OUTSTANDING).
  - Once arvalid is asserted, it and araddr stay stable until arready.
  - On arvalid & arready: ar_cnt+1, araddr+128, outstanding+1.
  - Go to DRAIN when ar_cnt reaches beat_tgt.
  - If beat_tgt = 0, go straight to DONE with no AXI traffic (done 2 cycles after start).
- State DRAIN: arvalid 0. Go to DONE when r_cnt == beat_tgt.
- State DONE: fetch_done = 1 (registered, level). Hold until the next fetch_start, which clears it on the following edge.
- R channel handling (any state): on rvalid (rready is always 1):
  - fetch_data <= {fetch_data[FETCH_WIDTH-DATA_WIDTH-1:0], rdata}
  - r_cnt+1, outstanding-1
  - rresp != 0 sets fetch_error. The beat is still counted and shifted.
- Data layout: after N beats, beat k (0-based) sits at bits [(N-k)*DATA_WIDTH-1 : (N-k-1)*DATA_WIDTH]. The first beat is most significant. Unused upper bits are 0.
- Simultaneous AR acceptance and R beat in the same cycle: outstanding is unchanged.
- fetch_data is valid only while fetch_done = 1. The consumer captures it before issuing the next start.
- Asynchronous reset mid-operation returns everything to reset values immediately. The interconnect is reset together with the block.

Test Plan:
1. beat_num=4, addr 0x1000, arready=1, rvalid 2 cycles after each AR:
   - Required: araddr sequence 0x1000, 0x1080, 0x1100, 0x1180.
   - Required: fetch_data[4095:0] = {b0,b1,b2,b3}, upper bits 0, fetch_done rises one cycle after the 4th R beat.
2. beat_num=32, no R responses for 50 cycles:
   - Required: exactly 8 ARs accepted, then arvalid stays 0.
   - Required: each R beat re-enables one AR. Completes with 32 beats, first beat in bits [32767:31744].
3. beat_num=40:
   - Required: clamped to 32. Exactly 32 ARs; done after the 32nd beat.
4. beat_num=0:
   - Required: no arvalid, fetch_done=1 two cycles after start, fetch_data=0.
5. beat_num=3, second R beat with rresp=2'b10:
   - Required: fetch_error=1 and fetch_done=1 after 3 beats; error clears on the next fetch_start.
6. fetch_start pulsed mid-DRAIN, then rst_n low mid-REQ:
   - Required: the start is ignored.
   - Required: reset forces arvalid=0, fetch_done=0 and fetch_data=0 asynchronously.
